hdc_class_sequencer: RTL

// - Query-level controller directly upstream of the HDC dot-product/classify core.
// - Accepts one query HV, walks class HVs 0..NUM_C-1 out of class memory into the core, drives class_L,

---
 rtl/hdc_class_sequencer_if.sv | 38 +++
 rtl/hdc_class_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/hdc_class_sequencer_if.sv
// Signal bundle between the HDC class sequencer and its query source, class memory,
// dot-product/classify core and result consumer.
interface hdc_class_sequencer_if #(
    parameter int D  = 8192,
    parameter int CW = 4
);
    logic          req_valid;
    logic          req_ready;
    logic [D-1:0]  req_hv;
    logic          mem_rd_en;
    logic [CW-1:0] mem_rd_addr;
    logic [D-1:0]  mem_rd_data;
    logic          core_start;
    logic [D-1:0]  core_in_hv;
    logic [D-1:0]  core_class_hv;
    logic [CW-1:0] core_class_L;
    logic          core_next_class;
    logic          core_done;
    logic [CW-1:0] core_pred_label;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] res_label;
    logic          busy;
    logic          err;

    // The sequencer itself takes the master view.
    modport master (
        input  req_valid, req_hv, mem_rd_data, core_next_class, core_done, core_pred_label, res_ready,
        output req_ready, mem_rd_en, mem_rd_addr, core_start, core_in_hv, core_class_hv, core_class_L,
               res_valid, res_label, busy, err
    );

    modport slave (
        output req_valid, req_hv, mem_rd_data, core_next_class, core_done, core_pred_label, res_ready,
        input  req_ready, mem_rd_en, mem_rd_addr, core_start, core_in_hv, core_class_hv, core_class_L,
               res_valid, res_label, busy, err
    );
endinterface

// File: rtl/hdc_class_sequencer.sv
// Query-level controller: latches one query HV, streams class HVs 0..NUM_C-1 from class memory
// into the classify core on its requests, and returns the winning label over valid/ready.
module hdc_class_sequencer #(
    parameter int D       = 8192,
    parameter int NUM_C   = 10,
    parameter int MEM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hdc_class_sequencer_if.master  bus
);
    localparam int CW = (NUM_C > 1) ? $clog2(NUM_C) : 1;
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_C - 1);
    localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, RUN, DRAIN, RESULT} state_t;

    state_t        state_q, state_d;
    logic          req_ready_q, req_ready_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [D-1:0]  in_hv_q, in_hv_d;
    logic [D-1:0]  class_hv_q, class_hv_d;
    logic [CW-1:0] class_L_q, class_L_d;
    logic          start_q, start_d;
    logic [CW-1:0] label_q, label_d;
    logic          done_seen_q, done_seen_d;
    logic          err_q, err_d;
    logic          last_simul;

    // req_ready is registered so that it too reads 0 while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            idx_q       <= '0;
            lat_q       <= '0;
            in_hv_q     <= '0;
            class_hv_q  <= '0;
            class_L_q   <= '0;
            start_q     <= 1'b0;
            label_q     <= '0;
            done_seen_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
            in_hv_q     <= in_hv_d;
            class_hv_q  <= class_hv_d;
            class_L_q   <= class_L_d;
            start_q     <= start_d;
            label_q     <= label_d;
            done_seen_q <= done_seen_d;
            err_q       <= err_d;
        end
    end

    assign last_simul = (state_q == RUN) && bus.core_next_class && bus.core_done && (idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        in_hv_d     = in_hv_q;
        class_hv_d  = class_hv_q;
        class_L_d   = class_L_q;
        start_d     = 1'b0;
        label_d     = label_q;
        done_seen_d = done_seen_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (req_ready_q && bus.req_valid) begin
                    in_hv_d     = bus.req_hv;
                    idx_d       = '0;
                    err_d       = 1'b0;
                    done_seen_d = 1'b0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                lat_d   = LAT_INIT;
                state_d = WAIT_MEM;
            end
            WAIT_MEM: begin
                if (lat_q == '0) begin
                    class_hv_d = bus.mem_rd_data;
                    class_L_d  = idx_q;
                    start_d    = (idx_q == '0);
                    state_d    = RUN;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            RUN: begin
                if (bus.core_next_class) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                        // Done arriving with the final request still counts; keep its label now.
                        if (bus.core_done) begin
                            done_seen_d = 1'b1;
                            label_d     = bus.core_pred_label;
                        end
                    end else begin
                        idx_d   = idx_q + CW'(1);
                        state_d = FETCH;
                    end
                end
            end
            DRAIN: begin
                if (done_seen_q) begin
                    state_d = RESULT;
                end else if (bus.core_done) begin
                    label_d = bus.core_pred_label;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.core_next_class && (state_q != RUN)) err_d = 1'b1;
        if (bus.core_done && (state_q != DRAIN) && !last_simul) err_d = 1'b1;
    end

    assign req_ready_d = (state_d == IDLE);

    assign bus.req_ready     = req_ready_q;
    assign bus.mem_rd_en     = (state_q == FETCH);
    assign bus.mem_rd_addr   = idx_q;
    assign bus.core_start    = start_q;
    assign bus.core_in_hv    = in_hv_q;
    assign bus.core_class_hv = class_hv_q;
    assign bus.core_class_L  = class_L_q;
    assign bus.res_valid     = (state_q == RESULT);
    assign bus.res_label     = label_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.err           = err_q;
endmodule
